// File: rtl/fir_mac_scheduler.sv
// Per-sample FIR equalizer sequencer: writes each accepted sample into the delay line,
// then walks every enabled equalizer tap by tap, driving the shared MAC unit.
module fir_mac_scheduler #(
  parameter int unsigned num_of_taps       = 64,
  parameter int unsigned num_of_equalizers = 8,
  parameter int unsigned mac_latency       = 2,
  localparam int unsigned TW = $clog2(num_of_taps),
  localparam int unsigned EW = (num_of_equalizers > 1) ? $clog2(num_of_equalizers) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         bypass,
  input  logic                         sample_en,
  input  logic                         sample_chan,
  input  logic [num_of_equalizers-1:0] eq_enable,
  input  logic                         overrun_clr,
  output logic                         chan_sel,
  output logic                         sample_wr_en,
  output logic [TW-1:0]                wr_ptr,
  output logic [TW-1:0]                rd_addr,
  output logic [EW-1:0]                coef_eq_sel,
  output logic [TW-1:0]                coef_tap,
  output logic                         mac_clr,
  output logic                         mac_en,
  output logic                         acc_capture,
  output logic [EW-1:0]                capture_eq,
  output logic                         busy,
  output logic                         sample_done,
  output logic                         overrun
);

  localparam int unsigned DW = $clog2(mac_latency) + 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(num_of_taps - 1);

  typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, DONE} state_t;

  state_t                         state;
  logic [num_of_equalizers-1:0]   en_q;
  logic [TW-1:0]                  ptr_q [2];
  logic [DW-1:0]                  drain_cnt;

  logic [EW-1:0]                  first_eq;
  logic                           first_vld;
  logic [EW-1:0]                  next_eq;
  logic                           next_vld;

  logic [mac_latency-1:0]         cap_pipe;
  logic [EW-1:0]                  eq_pipe [mac_latency];

  // Scanning from the top down leaves the lowest qualifying index as the final assignment.
  always_comb begin
    first_eq  = '0;
    first_vld = 1'b0;
    next_eq   = '0;
    next_vld  = 1'b0;
    for (int unsigned i = num_of_equalizers; i > 0; i--) begin
      if (en_q[i-1]) begin
        first_eq  = EW'(i - 1);
        first_vld = 1'b1;
      end
      if (en_q[i-1] && ((i - 1) > 32'(coef_eq_sel))) begin
        next_eq  = EW'(i - 1);
        next_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      en_q         <= '0;
      ptr_q[0]     <= '0;
      ptr_q[1]     <= '0;
      drain_cnt    <= '0;
      chan_sel     <= 1'b0;
      sample_wr_en <= 1'b0;
      wr_ptr       <= '0;
      rd_addr      <= '0;
      coef_eq_sel  <= '0;
      coef_tap     <= '0;
      mac_clr      <= 1'b0;
      mac_en       <= 1'b0;
      busy         <= 1'b0;
      sample_done  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_wr_en <= 1'b0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      sample_done  <= 1'b0;

      if (sample_en && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (sample_en && !bypass) begin
            state        <= WRITE;
            chan_sel     <= sample_chan;
            en_q         <= eq_enable;
            busy         <= 1'b1;
            sample_wr_en <= 1'b1;
            wr_ptr       <= ptr_q[sample_chan];
          end
        end
        WRITE: begin
          if (first_vld) begin
            state       <= MAC;
            mac_en      <= 1'b1;
            mac_clr     <= 1'b1;
            coef_eq_sel <= first_eq;
            coef_tap    <= '0;
            rd_addr     <= wr_ptr;
          end else begin
            state       <= DONE;
            sample_done <= 1'b1;
          end
        end
        MAC: begin
          if (coef_tap == LAST_TAP) begin
            if (next_vld) begin
              mac_en      <= 1'b1;
              mac_clr     <= 1'b1;
              coef_eq_sel <= next_eq;
              coef_tap    <= '0;
              rd_addr     <= wr_ptr;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            mac_en   <= 1'b1;
            coef_tap <= coef_tap + TW'(1);
            rd_addr  <= wr_ptr - coef_tap - TW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(mac_latency - 1)) begin
            state       <= DONE;
            sample_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state           <= IDLE;
          busy            <= 1'b0;
          ptr_q[chan_sel] <= wr_ptr + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last-tap marker and its equalizer index travel together through the MAC latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_pipe <= '0;
      for (int unsigned i = 0; i < mac_latency; i++) begin
        eq_pipe[i] <= '0;
      end
    end else begin
      cap_pipe[0] <= mac_en && (coef_tap == LAST_TAP);
      eq_pipe[0]  <= coef_eq_sel;
      for (int unsigned i = 1; i < mac_latency; i++) begin
        cap_pipe[i] <= cap_pipe[i-1];
        eq_pipe[i]  <= eq_pipe[i-1];
      end
    end
  end

  assign acc_capture = cap_pipe[mac_latency-1];
  assign capture_eq  = eq_pipe[mac_latency-1];

endmodule
